lms_stimulus_gen: RTL
=====================

Name: lms_stimulus_gen

Overview:
- Upstream source for the adaptive LMS filter core.
- Produces the input sample x and the desired response d as a pair, handed over on a valid/ready handshake.
- x is pseudo-random and comes from an LFSR. d is x passed through a fixed 4-tap "unknown plant" FIR, which the LMS weights must converge to.
- Runs a bounded burst of NUM_SAMPLES pairs per start request, then reports done.

Parameters:
- DATA_W, 16, width of x_out and d_out (two's complement).
- NUM_SAMPLES, 25, number of pairs emitted per run.
- SEED, 16'hACE1, LFSR load value. A value of 0 is replaced by 16'h0001.
- H0, 3, plant tap 0 (signed integer), applied to x[n].
- H1, -2, plant tap 1, applied to x[n-1].
- H2, 1, plant tap 2, applied to x[n-2].
- H3, 0, plant tap 3, applied to x[n-3].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a run. Honoured only in IDLE or DONE.
- out_ready  in  1  downstream filter can accept a pair.
- out_valid  out  1  x_out/d_out hold a valid pair.
- x_out  out  DATA_W  input sample x[n].
- d_out  out  DATA_W  desired sample d[n].
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- sample_cnt  out  $clog2(NUM_SAMPLES+1)  number of pairs accepted in the current run.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, lfsr=SEED, history all 0, out_valid=0, x_out=0, d_out=0, busy=0, done=0, sample_cnt=0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1 → RUN next cycle. On that edge: lfsr reloads SEED, history clears, sample_cnt clears, done drops.
- start in RUN is ignored.
- Generate event: in RUN, when (!out_valid || out_ready) and produced < NUM_SAMPLES.
  - x_new = sign-extend(lfsr[3:0]) to DATA_W, range -8..7.
  - d_new = H0*x_new + H1*h[0] + H2*h[1] + H3*h[2], where h[0..2] are the three previous x values.
  - Accumulate d_new in DATA_W+8 bits, then saturate to DATA_W signed.
  - Registered: x_out=x_new, d_out=d_new, out_valid=1.
  - History shifts: h[2]=h[1], h[1]=h[0], h[0]=x_new.
  - lfsr advances one step.
- Latency: the first pair is valid 1 cycle after the RUN-entry edge, i.e. the 2nd clk edge after start.
- With out_ready held high, one pair per cycle is produced.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - fb = l[15]^l[13]^l[12]^l[10].
  - next = {l[14:0], fb}.
  - The all-zero state is unreachable.
- Handshake:
  - Transfer occurs when out_valid && out_ready at a rising edge.
  - While out_valid && !out_ready, x_out/d_out/lfsr/history are held stable. No sample is skipped or repeated.
  - sample_cnt increments on each transfer.
- Transfer with simultaneous generate: the new pair loads in the same cycle (back-to-back), and out_valid stays 1.
- Final transfer (sample_cnt reaches NUM_SAMPLES): out_valid→0, state→DONE, done=1, busy=0.
- x_out/d_out keep their last values in DONE.
- start arriving on the same edge as the final transfer is ignored. It is honoured on a later cycle in DONE.
- Reset mid-run: immediate return to the reset values. Any pending valid is dropped.

Decomposition:
- Package lms_pkg holds:
  - DATA_W default;
  - plant tap constants;
  - LFSR polynomial mask and default seed;
  - the state enum typedef (IDLE, RUN, DONE);
  - a signed sample typedef shared with the filter core.
- Sub-module lfsr16 (enable, load, seed, state out) is natural. The FSM, plant FIR and handshake stay in the top of this block.

Test Plan:
1. Sequence check: reset, start, out_ready=1, SEED=ACE1 → pairs (x,d) = (1,3), (3,7), (7,16), (-1,-14); the LFSR state walks ACE1 → 59C3 → B387 → 670F.
2. Backpressure: out_ready=0 for 5 cycles after the 2nd pair → (3,7) is held stable with out_valid=1; after release, the next pair is (7,16) and no value is lost.
3. Run length: NUM_SAMPLES=25, out_ready=1 → exactly 25 transfers; sample_cnt=25, done=1, out_valid=0; a start in DONE replays an identical sequence beginning with (1,3).
4. Start during RUN: pulse start at pair 10 → ignored; sample_cnt and sequence continue unchanged.
5. Async reset mid-run: drop rst between clock edges at pair 6 → outputs go to zero immediately; after release plus start, the sequence restarts at (1,3).
6. Saturation: DATA_W=6 (range -32..31), taps H0=5, H1=-5, H2=5 → d_out clamps to 31/-32 and never wraps; compare against a reference model.

Source files
------------

// File: rtl/lms_stimulus_gen_pkg.sv
// Shared definitions for the LMS stimulus source and the filter core that consumes it:
// default widths, plant taps, LFSR constants, state encoding and the sample type.
package lms_pkg;

    localparam int          DATA_W_DEF      = 16;
    localparam int          NUM_SAMPLES_DEF = 25;

    // Unknown-plant FIR taps the LMS weights are expected to converge to.
    localparam int          H0_DEF = 3;
    localparam int          H1_DEF = -2;
    localparam int          H2_DEF = 1;
    localparam int          H3_DEF = 0;

    // Taps 16,14,13,11 of x^16+x^14+x^13+x^11+1 map to state bits 15,13,12,10.
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [15:0] SEED_DEF  = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } lms_state_e;

    typedef logic signed [DATA_W_DEF-1:0] lms_sample_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        logic [15:0] r;
        if (s == 16'h0000) begin
            r = 16'h0001;
        end else begin
            r = s;
        end
        return r;
    endfunction

    // One Fibonacci step: feedback is the parity of the tapped bits.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_MASK)};
    endfunction

endpackage

// File: rtl/lms_stimulus_gen_if.sv
// Valid/ready sample-pair channel from the stimulus source to the LMS filter core.
interface lms_stimulus_gen_if #(
    parameter int DATA_W = 16
) ();

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] x_out;
    logic signed [DATA_W-1:0] d_out;

    modport master (
        output out_valid,
        output x_out,
        output d_out,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  x_out,
        input  d_out,
        output out_ready
    );

endinterface

// File: rtl/lms_stimulus_gen_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload; load takes priority over stepping.
module lfsr16
    import lms_pkg::*;
#(
    parameter logic [15:0] INIT = SEED_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_r;

    // LFSR state register: reset to INIT, reload on load, advance on en
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= INIT;
        end else if (load) begin
            state_r <= seed;
        end else if (en) begin
            state_r <= lfsr_step(state_r);
        end
    end

    assign state = state_r;

endmodule

// File: rtl/lms_stimulus_gen.sv
// LMS stimulus source: emits NUM_SAMPLES (x, d) pairs per start, where x is LFSR noise
// and d is x filtered by a fixed 4-tap plant, saturated to DATA_W.
module lms_stimulus_gen
    import lms_pkg::*;
#(
    parameter int          DATA_W      = DATA_W_DEF,
    parameter int          NUM_SAMPLES = NUM_SAMPLES_DEF,
    parameter logic [15:0] SEED        = SEED_DEF,
    parameter int          H0          = H0_DEF,
    parameter int          H1          = H1_DEF,
    parameter int          H2          = H2_DEF,
    parameter int          H3          = H3_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    lms_stimulus_gen_if.master                     stim,
    output logic                                   busy,
    output logic                                   done,
    output logic [$clog2(NUM_SAMPLES+1)-1:0]       sample_cnt
);

    localparam int          ACC_W    = DATA_W + 8;
    localparam int          CNT_W    = $clog2(NUM_SAMPLES + 1);
    localparam logic [15:0] SEED_EFF = seed_fix(SEED);

    localparam logic [1:0]  S_IDLE = ST_IDLE;
    localparam logic [1:0]  S_RUN  = ST_RUN;
    localparam logic [1:0]  S_DONE = ST_DONE;

    localparam logic signed [ACC_W-1:0] H0_A = ACC_W'(H0);
    localparam logic signed [ACC_W-1:0] H1_A = ACC_W'(H1);
    localparam logic signed [ACC_W-1:0] H2_A = ACC_W'(H2);
    localparam logic signed [ACC_W-1:0] H3_A = ACC_W'(H3);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [1:0]               state_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     out_valid_r;
    logic signed [DATA_W-1:0] x_out_r;
    logic signed [DATA_W-1:0] d_out_r;
    logic signed [DATA_W-1:0] h0_r;
    logic signed [DATA_W-1:0] h1_r;
    logic signed [DATA_W-1:0] h2_r;
    logic [CNT_W-1:0]         sample_cnt_r;
    logic [CNT_W-1:0]         produced_r;

    logic [15:0]              lfsr_s;
    logic                     lfsr_unused_s;
    logic                     start_ok_s;
    logic                     gen_s;
    logic                     xfer_s;
    logic                     last_s;
    logic signed [DATA_W-1:0] x_new_s;
    logic signed [DATA_W-1:0] d_new_s;
    logic signed [ACC_W-1:0]  acc_s;

    lfsr16 #(
        .INIT (SEED_EFF)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (gen_s),
        .load  (start_ok_s),
        .seed  (SEED_EFF),
        .state (lfsr_s)
    );

    // Only the low nibble drives the sample; the rest is LFSR internal state.
    assign lfsr_unused_s = ^lfsr_s[15:4];

    // Handshake decode: run acceptance, generate, transfer and final-transfer strobes
    always_comb begin
        start_ok_s = 1'b0;
        gen_s      = 1'b0;
        xfer_s     = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                start_ok_s = start;
            end
            S_RUN: begin
                xfer_s = out_valid_r && stim.out_ready;
                gen_s  = (!out_valid_r || stim.out_ready) &&
                         (produced_r < CNT_W'(NUM_SAMPLES));
                last_s = xfer_s && (sample_cnt_r == CNT_W'(NUM_SAMPLES - 1));
            end
            default: begin
                start_ok_s = 1'b0;
            end
        endcase
    end

    // Plant FIR on the new sample and history, accumulated wide then clamped
    always_comb begin
        x_new_s = {{(DATA_W-4){lfsr_s[3]}}, lfsr_s[3:0]};
        acc_s   = H0_A * {{8{x_new_s[DATA_W-1]}}, x_new_s}
                + H1_A * {{8{h0_r[DATA_W-1]}}, h0_r}
                + H2_A * {{8{h1_r[DATA_W-1]}}, h1_r}
                + H3_A * {{8{h2_r[DATA_W-1]}}, h2_r};
        if (acc_s > SAT_MAX) begin
            d_new_s = SAT_MAX[DATA_W-1:0];
        end else if (acc_s < SAT_MIN) begin
            d_new_s = SAT_MIN[DATA_W-1:0];
        end else begin
            d_new_s = acc_s[DATA_W-1:0];
        end
    end

    // Run-control FSM with registered busy/done flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start_ok_s) begin
                        state_r <= S_RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (last_s) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Accepted-pair and generated-pair counters, cleared when a run starts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt_r <= '0;
            produced_r   <= '0;
        end else if (start_ok_s) begin
            sample_cnt_r <= '0;
            produced_r   <= '0;
        end else begin
            if (gen_s) begin
                produced_r <= produced_r + CNT_W'(1);
            end
            if (xfer_s) begin
                sample_cnt_r <= sample_cnt_r + CNT_W'(1);
            end
        end
    end

    // Output pair register: loads on generate, empties on a transfer with nothing new
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            x_out_r     <= '0;
            d_out_r     <= '0;
        end else if (gen_s) begin
            out_valid_r <= 1'b1;
            x_out_r     <= x_new_s;
            d_out_r     <= d_new_s;
        end else if (xfer_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Plant delay line holding the three previous x samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h0_r <= '0;
            h1_r <= '0;
            h2_r <= '0;
        end else if (start_ok_s) begin
            h0_r <= '0;
            h1_r <= '0;
            h2_r <= '0;
        end else if (gen_s) begin
            h2_r <= h1_r;
            h1_r <= h0_r;
            h0_r <= x_new_s;
        end
    end

    assign stim.out_valid = out_valid_r;
    assign stim.x_out     = x_out_r;
    assign stim.d_out     = d_out_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign sample_cnt     = sample_cnt_r;

endmodule
